// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: entry/exit lane sequencer with shadow occupancy and serialised INC/DEC issue (optional PARKING_CHECK_EN)
module parking_gate_ctrl #(
    parameter logic [4:0] MAX = 5'd25
) (
    input  logic       CLOCK_50,
    input  logic       RST,
    input  logic       ENT_A,
    input  logic       ENT_B,
    input  logic       EXT_A,
    input  logic       EXT_B,
    input  logic [4:0] cntNum,
    output logic       INC,
    output logic       DEC,
    output logic       ENT_OPEN,
    output logic       EXT_OPEN,
    output logic       FULL,
    output logic       EMPTY,
    output logic       MISMATCH
);
    typedef enum logic [1:0] {IDLE, OUTER, BOTH, INNER} lane_t;

    lane_t      ent_q, ent_d, ext_q, ext_d;
    logic [4:0] occ_q, occ_d;
    logic [1:0] pend_in_q, pend_in_d, pend_out_q, pend_out_d;
    logic       rr_q, rr_d, inc_q, inc_d, dec_q, dec_d;
    logic       ent_done, ext_done, gnt_in, gnt_out;

    function automatic lane_t lane_next(input lane_t s, input logic a, input logic b, input logic en);
        case (s)
            IDLE:    lane_next = (en && a && !b) ? OUTER : IDLE;
            OUTER:   lane_next = (a && b) ? BOTH : (!a && !b) ? IDLE : OUTER;
            BOTH:    lane_next = (!a && b) ? INNER : (a && !b) ? OUTER : BOTH;
            default: lane_next = (!a && !b) ? IDLE : (a && b) ? BOTH : INNER;
        endcase
    endfunction

    function automatic logic [1:0] pend_next(input logic [1:0] p, input logic add, input logic sub);
        pend_next = (add && !sub) ? ((p == 2'd3) ? p : p + 2'd1) : (sub && !add) ? p - 2'd1 : p;
    endfunction

    // lane sequencing, occupancy tracking and one-op-per-cycle round-robin issue
    always_comb begin
        ent_d      = lane_next(ent_q, ENT_A, ENT_B, occ_q < MAX);
        ext_d      = lane_next(ext_q, EXT_A, EXT_B, occ_q != 5'd0);
        ent_done   = (ent_q == INNER) && !ENT_A && !ENT_B;
        ext_done   = (ext_q == INNER) && !EXT_A && !EXT_B;
        occ_d      = (ent_done && !ext_done && occ_q < MAX) ? occ_q + 5'd1 :
                     (ext_done && !ent_done && occ_q != 5'd0) ? occ_q - 5'd1 : occ_q;
        gnt_in     = (pend_in_q != 2'd0) && ((pend_out_q == 2'd0) || !rr_q);
        gnt_out    = (pend_out_q != 2'd0) && !gnt_in;
        pend_in_d  = pend_next(pend_in_q, ent_done, gnt_in);
        pend_out_d = pend_next(pend_out_q, ext_done, gnt_out);
        rr_d       = ((pend_in_q != 2'd0) && (pend_out_q != 2'd0)) ? !rr_q : rr_q;
        inc_d      = gnt_in;
        dec_d      = gnt_out;
    end

    // state registers; reset aborts passages and discards pending ops
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            ent_q      <= IDLE;
            ext_q      <= IDLE;
            occ_q      <= 5'd0;
            pend_in_q  <= 2'd0;
            pend_out_q <= 2'd0;
            rr_q       <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
        end else begin
            ent_q      <= ent_d;
            ext_q      <= ext_d;
            occ_q      <= occ_d;
            pend_in_q  <= pend_in_d;
            pend_out_q <= pend_out_d;
            rr_q       <= rr_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
        end
    end

    assign INC      = inc_q;
    assign DEC      = dec_q;
    assign ENT_OPEN = ent_q != IDLE;
    assign EXT_OPEN = ext_q != IDLE;
    assign FULL     = occ_q == MAX;
    assign EMPTY    = occ_q == 5'd0;

`ifdef PARKING_CHECK_EN
    logic mis_q, mis_d;

    // sticky compare of the external count against occ once no ops are in flight
    always_comb begin
        mis_d = mis_q || ((pend_in_q == 2'd0) && (pend_out_q == 2'd0) && !inc_q && !dec_q && (cntNum != occ_q));
    end

    // mismatch flag register
    always_ff @(posedge CLOCK_50) begin
        if (RST) mis_q <= 1'b0;
        else     mis_q <= mis_d;
    end

    assign MISMATCH = mis_q;
`else
    logic unused_cnt;

    assign unused_cnt = ^cntNum;
    assign MISMATCH   = 1'b0;
`endif
endmodule

// File: tb/tb_parking_gate_ctrl.sv
// tb_parking_gate_ctrl: vector table plus hand sequences, INC/DEC checked through a timed scoreboard
module tb_parking_gate_ctrl;
    logic       clk = 1'b0, RST = 1'b1;
    logic       ENT_A = 1'b0, ENT_B = 1'b0, EXT_A = 1'b0, EXT_B = 1'b0;
    logic [4:0] cntNum, cnt, ov_val;
    logic       ov_en = 1'b0;
    logic       INC, DEC, ENT_OPEN, EXT_OPEN, FULL, EMPTY, MISMATCH;

    typedef struct packed {logic [3:0] s; logic [1:0] o; logic [1:0] d;} vec_t;
    typedef struct {logic is_inc; int cyc;} op_t;

    op_t  sb[$];
    int   cyc = 0, compared = 0, errors = 0, exp_occ = 0;
    vec_t tbl[24];

    parking_gate_ctrl dut (
        .CLOCK_50(clk), .RST(RST), .ENT_A(ENT_A), .ENT_B(ENT_B), .EXT_A(EXT_A), .EXT_B(EXT_B),
        .cntNum(cntNum), .INC(INC), .DEC(DEC), .ENT_OPEN(ENT_OPEN), .EXT_OPEN(EXT_OPEN),
        .FULL(FULL), .EMPTY(EMPTY), .MISMATCH(MISMATCH)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // external car-count block model
    always @(posedge clk) begin
        if (RST) cnt <= 5'd0;
        else if (INC) cnt <= cnt + 5'd1;
        else if (DEC) cnt <= cnt - 5'd1;
    end

    assign cntNum = ov_en ? ov_val : cnt;

    always @(negedge clk) begin
        if (INC && DEC) begin
            compared++; errors++;
            $display("FAIL both_ops: got INC=1 DEC=1 expected at most one at cycle %0d", cyc);
        end
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            compared++; errors++;
            $display("FAIL missing_op: got none expected %s at cycle %0d", sb[0].is_inc ? "INC" : "DEC", sb[0].cyc);
            void'(sb.pop_front());
        end
        if (INC || DEC) begin
            compared++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_op: got INC=%b DEC=%b expected none at cycle %0d", INC, DEC, cyc);
            end else if (sb[0].is_inc !== INC || sb[0].cyc != cyc) begin
                errors++;
                $display("FAIL op_order: got INC=%b at cycle %0d expected INC=%b at cycle %0d", INC, cyc, sb[0].is_inc, sb[0].cyc);
                void'(sb.pop_front());
            end else begin
                void'(sb.pop_front());
            end
        end
    end

    task automatic chk(input string n, input int act, input int exp);
        compared++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic step(input logic [3:0] s, input logic [1:0] o, input logic [1:0] d);
        @(negedge clk);
        {ENT_A, ENT_B, EXT_A, EXT_B} = s;
        @(posedge clk);
        #1;
        chk("ent_open", ENT_OPEN, o[1]);
        chk("ext_open", EXT_OPEN, o[0]);
        if (d == 2'b11) begin
            sb.push_back('{1'b1, cyc + 1});
            sb.push_back('{1'b0, cyc + 2});
        end else if (d[1]) begin
            sb.push_back('{1'b1, cyc + 1});
            exp_occ++;
        end else if (d[0]) begin
            sb.push_back('{1'b0, cyc + 1});
            exp_occ--;
        end
        chk("full", FULL, exp_occ == 25);
        chk("empty", EMPTY, exp_occ == 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0000, 2'b00, 2'b00);
    endtask

    task automatic ent_pass();
        step(4'b1000, 2'b10, 2'b00);
        step(4'b1100, 2'b10, 2'b00);
        step(4'b0100, 2'b10, 2'b00);
        step(4'b0000, 2'b00, 2'b10);
        idle(1);
    endtask

    task automatic ext_pass();
        step(4'b0010, 2'b01, 2'b00);
        step(4'b0011, 2'b01, 2'b00);
        step(4'b0001, 2'b01, 2'b00);
        step(4'b0000, 2'b00, 2'b01);
        idle(1);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        RST = 1'b1;
        {ENT_A, ENT_B, EXT_A, EXT_B} = 4'b0000;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_inc", INC, 0);
        chk("rst_dec", DEC, 0);
        chk("rst_ent_open", ENT_OPEN, 0);
        chk("rst_ext_open", EXT_OPEN, 0);
        chk("rst_mismatch", MISMATCH, 0);
        @(negedge clk);
        RST = 1'b0;
        exp_occ = 0;
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000ns");
        $fatal(1);
    end

    initial begin
        tbl = '{
            {4'b1000, 2'b10, 2'b00}, {4'b1100, 2'b10, 2'b00}, {4'b0100, 2'b10, 2'b00}, {4'b0000, 2'b00, 2'b10},
            {4'b1000, 2'b10, 2'b00}, {4'b0000, 2'b00, 2'b00},
            {4'b1000, 2'b10, 2'b00}, {4'b1100, 2'b10, 2'b00}, {4'b1000, 2'b10, 2'b00}, {4'b1100, 2'b10, 2'b00},
            {4'b0100, 2'b10, 2'b00}, {4'b0000, 2'b00, 2'b10},
            {4'b0000, 2'b00, 2'b00},
            {4'b0010, 2'b01, 2'b00}, {4'b0011, 2'b01, 2'b00}, {4'b0001, 2'b01, 2'b00}, {4'b0000, 2'b00, 2'b01},
            {4'b0000, 2'b00, 2'b00},
            {4'b1010, 2'b11, 2'b00}, {4'b1111, 2'b11, 2'b00}, {4'b0101, 2'b11, 2'b00}, {4'b0000, 2'b00, 2'b11},
            {4'b0000, 2'b00, 2'b00}, {4'b0000, 2'b00, 2'b00}
        };
        do_reset(2);
        foreach (tbl[i]) step(tbl[i].s, tbl[i].o, tbl[i].d);
        idle(3);
        chk("cnt_after_table", cnt, exp_occ);
        step(4'b1000, 2'b10, 2'b00);
        step(4'b1100, 2'b10, 2'b00);
        do_reset(1);
        idle(2);
        chk("cnt_after_abort_rst", cnt, 0);
        while (exp_occ < 5) ent_pass();
        idle(2);
        step(4'b1010, 2'b11, 2'b00);
        step(4'b1111, 2'b11, 2'b00);
        step(4'b0101, 2'b11, 2'b00);
        step(4'b0000, 2'b00, 2'b11);
        idle(4);
        chk("cnt_simul_5", cnt, 5);
        while (exp_occ < 25) ent_pass();
        idle(2);
        chk("cnt_full", cnt, 25);
        step(4'b1000, 2'b00, 2'b00);
        step(4'b1000, 2'b00, 2'b00);
        step(4'b1100, 2'b00, 2'b00);
        step(4'b0100, 2'b00, 2'b00);
        idle(3);
        while (exp_occ > 0) ext_pass();
        idle(2);
        chk("cnt_empty", cnt, 0);
        step(4'b0010, 2'b00, 2'b00);
        step(4'b0010, 2'b00, 2'b00);
        step(4'b0011, 2'b00, 2'b00);
        step(4'b0001, 2'b00, 2'b00);
        idle(3);
`ifdef PARKING_CHECK_EN
        do_reset(1);
        while (exp_occ < 4) ent_pass();
        idle(3);
        chk("mismatch_quiet", MISMATCH, 0);
        ov_val = 5'd3;
        ov_en = 1'b1;
        idle(1);
        chk("mismatch_set", MISMATCH, 1);
        ov_en = 1'b0;
        idle(3);
        chk("mismatch_sticky", MISMATCH, 1);
        do_reset(1);
`else
        chk("mismatch_tied", MISMATCH, 0);
`endif
        idle(4);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end
endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
- Sequences the parking-lot entry and exit lanes.
- Decodes two-sensor car passages per lane, controls both gate barriers, and tracks a shadow occupancy.
- Produces single-cycle INC/DEC commands for the car-count block (one op per cycle max, INC priority there), serialising simultaneous entry/exit events so none are lost.

Parameters:
- MAX, 5'd25, lot capacity; entry gate stays closed when occupancy == MAX.

Ports:
- CLOCK_50  in  1  system clock
- RST  in  1  synchronous reset, active-high
- ENT_A  in  1  entry outer sensor (1 = car present)
- ENT_B  in  1  entry inner sensor
- EXT_A  in  1  exit inner sensor (lot side)
- EXT_B  in  1  exit outer sensor (street side)
- cntNum  in  5  current count from the car-count block (used only with CHECK_EN)
- INC  out  1  one-cycle increment command to the counter
- DEC  out  1  one-cycle decrement command to the counter
- ENT_OPEN  out  1  entry barrier raise
- EXT_OPEN  out  1  exit barrier raise
- FULL  out  1  occ == MAX
- EMPTY  out  1  occ == 0
- MISMATCH  out  1  counter/shadow disagreement flag

Behaviour:
- Single clock domain. All state updates on posedge CLOCK_50. RST is sampled synchronously.
- Reset values: both lane FSMs in IDLE, occ=0, pend_in=pend_out=0, rr=ENTRY. Outputs: INC=DEC=0, ENT_OPEN=EXT_OPEN=0, FULL=0, EMPTY=1, MISMATCH=0.
- RST asserted mid-passage aborts the passage: no count, FSMs return to IDLE, pending ops are discarded.
- Lane FSM: states IDLE, OUTER, BOTH, INNER. The same FSM is used per lane; for the exit lane, A = EXT_A and B = EXT_B.
  - IDLE -> OUTER on A&~B, only if enabled. The entry lane is enabled when occ < MAX; the exit lane is enabled when occ > 0.
  - OUTER -> BOTH on A&B. OUTER -> IDLE on ~A&~B (abort, no count).
  - BOTH -> INNER on ~A&B. BOTH -> OUTER on A&~B (car backing up).
  - INNER -> IDLE on ~A&~B: completion event. INNER -> BOTH on A&B.
  - Any other sensor combination holds the current state. A disabled lane ignores sensors while in IDLE.
- ENT_OPEN = (entry FSM != IDLE). EXT_OPEN = (exit FSM != IDLE). Both are decoded from state registers, so they rise the cycle after the enabling sensor sample.
- Occupancy: 5-bit occ, updated at the completion edge.
  - Entry completion only: +1.
  - Exit completion only: -1.
  - Both in the same cycle: unchanged.
  - Never exceeds MAX or drops below 0: the lane enables guarantee this; add saturating guards anyway.
- FULL and EMPTY are decoded from occ.
- Pending queues: pend_in and pend_out are 2-bit counters, each +1 on its lane's completion, saturating at 3.
- Issue arbiter, one decision per cycle:
  - If only pend_in > 0: INC=1 next cycle, pend_in -1.
  - If only pend_out > 0: DEC=1 next cycle, pend_out -1.
  - If both > 0: grant the rr side, then toggle rr.
  - INC and DEC are never high together.
- Latency: a completion sampled at edge E produces INC/DEC high for exactly one cycle starting at edge E+1 if uncontended, or E+2 if it lost arbitration.
- A completion and a drain in the same cycle on one queue leave that count unchanged.

Optional Feature:
- Macro: PARKING_CHECK_EN.
- Defined:
  - "Quiet" means pend_in==0, pend_out==0, and INC==DEC==0 in the previous cycle.
  - When quiet, cntNum != occ sets MISMATCH. MISMATCH is sticky until RST.
- Undefined: MISMATCH is tied to 0 and cntNum is unused.

Test Plan:
- Reset then idle: RST=1 for 2 cycles -> EMPTY=1, FULL=0, INC=DEC=0, both OPEN=0, occ=0.
- Entry passage: ENT_(A,B) = 10,11,01,00, one sample each -> ENT_OPEN high from cycle 2 to cycle 4; INC pulses once the cycle after 00 is sampled; occ=1; EMPTY=0.
- Abort and back-up: entry 10,00 -> no INC. Entry 10,11,10,11,01,00 -> exactly one INC.
- Simultaneous completion at edge E with occ=5, rr=ENTRY -> INC at E+1, DEC at E+2, occ stays 5, cntNum returns to 5.
- Full/empty gating:
  - Fill to occ=25 -> FULL=1; entry sensor 10 keeps ENT_OPEN=0 and produces no INC.
  - At occ=0, exit sensor 10 -> EXT_OPEN=0, no DEC.
- With PARKING_CHECK_EN: force cntNum=3 while occ=4 and quiet -> MISMATCH=1 next cycle, held until RST.
